// File: rtl/inst_writeback_queue_if.sv
// Late-result channel between multi-cycle units (divider, uncached loads)
// and the writeback queue.
//   late_valid  master -> slave  a late result is offered this cycle
//   late_ready  slave  -> master the queue can take it this cycle
//   late_rd     master -> slave  destination register (0 = no write)
//   late_val    master -> slave  result value
interface inst_writeback_queue_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic              late_valid;
    logic              late_ready;
    logic [ADDR_W-1:0] late_rd;
    logic [DATA_W-1:0] late_val;

    modport master (output late_valid, output late_rd, output late_val, input late_ready);
    modport slave  (input late_valid, input late_rd, input late_val, output late_ready);
endinterface

// File: rtl/inst_writeback_queue.sv
// Writeback stage: arbitrates the single register-file write port between the
// in-order pipeline result (priority) and an ordered queue of late results.
// Also provides forwarding from pending writes, a starvation stall that
// forces a queue drain, and retired PC/instruction tracking.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pipe_valid/pc_in/inst/rd/rd_val  current pipeline slot
//   late (slave modport)          late-result channel
//   stall                         registered; upstream holds its slot
//   fwd_addr/fwd_hit/fwd_val      combinational forwarding lookup
//   reg_addr/reg_din/reg_we       register-file write port (same cycle)
//   retire_valid/pc_out/inst_out  registered retire tracking
//   pending                       queue occupancy incl. squashed entries
module inst_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    parameter int STARVE = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_valid,
    input  logic [31:2]                pc_in,
    input  logic [31:0]                inst,
    input  logic [ADDR_W-1:0]          rd,
    input  logic [DATA_W-1:0]          rd_val,
    inst_writeback_queue_if.slave      late,
    output logic                       stall,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_val,
    output logic [ADDR_W-1:0]          reg_addr,
    output logic [DATA_W-1:0]          reg_din,
    output logic                       reg_we,
    output logic                       retire_valid,
    output logic [31:2]                pc_out,
    output logic [31:0]                inst_out,
    output logic [$clog2(DEPTH+1)-1:0] pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SC_W  = $clog2(STARVE+1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [SC_W-1:0]   SC_ZERO   = {SC_W{1'b0}};
    localparam logic [SC_W-1:0]   SC_ONE    = SC_W'(1);
    localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(STARVE-1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Queue storage; entries stay in place until popped, squash only clears valid.
    logic [ADDR_W-1:0] q_addr_r [DEPTH];
    logic [DATA_W-1:0] q_data_r [DEPTH];
    logic [DEPTH-1:0]  q_vld_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [SC_W-1:0]   starve_r;
    logic              stall_r;
    logic              retire_valid_r;
    logic [31:2]       pc_out_r;
    logic [31:0]       inst_out_r;

    logic slot_s;
    logic pw_s;
    logic empty_s;
    logic pop_s;
    logic late_ready_s;
    logic enq_s;

    // A stalled slot is invisible: no write, no retire, no forward.
    assign slot_s       = pipe_valid && !stall_r && !rst;
    assign pw_s         = slot_s && (rd != ADDR_ZERO);
    assign empty_s      = (count_r == CNT_ZERO);
    assign pop_s        = !pw_s && !empty_s && !rst;
    // Depends only on occupancy, so a full queue refuses even while draining.
    assign late_ready_s = (count_r < CNT_FULL) && !rst;
    // r0 results and results the same-cycle pipeline write supersedes are dropped.
    assign enq_s        = late.late_valid && late_ready_s &&
                          (late.late_rd != ADDR_ZERO) &&
                          !(pw_s && (late.late_rd == rd));

    assign late.late_ready = late_ready_s;
    assign stall           = stall_r;
    assign retire_valid    = retire_valid_r;
    assign pc_out          = pc_out_r;
    assign inst_out        = inst_out_r;
    assign pending         = count_r;

    // Write-port mux: pipeline first, else the head drains (squashed head writes nothing).
    always_comb begin
        reg_we   = 1'b0;
        reg_addr = ADDR_ZERO;
        reg_din  = DATA_ZERO;
        if (pw_s) begin
            reg_we   = 1'b1;
            reg_addr = rd;
            reg_din  = rd_val;
        end else if (pop_s) begin
            reg_we   = q_vld_r[head_r];
            reg_addr = q_addr_r[head_r];
            reg_din  = q_data_r[head_r];
        end else begin
            reg_we   = 1'b0;
        end
    end

    // Forwarding: pipeline slot wins, else the youngest valid matching queue entry.
    always_comb begin : fwd_blk
        logic [PTR_W-1:0] idx;
        logic             m;
        fwd_hit = 1'b0;
        fwd_val = DATA_ZERO;
        idx     = PTR_ZERO;
        m       = 1'b0;
        if (rst || (fwd_addr == ADDR_ZERO)) begin
            fwd_hit = 1'b0;
        end else if (pw_s && (rd == fwd_addr)) begin
            fwd_hit = 1'b1;
            fwd_val = rd_val;
        end else begin
            // Walk oldest to youngest so the last match is the youngest.
            for (int i = 0; i < DEPTH; i++) begin
                idx     = head_r + PTR_W'(i);
                m       = (CNT_W'(i) < count_r) && q_vld_r[idx] && (q_addr_r[idx] == fwd_addr);
                fwd_hit = fwd_hit | m;
                fwd_val = m ? q_data_r[idx] : fwd_val;
            end
        end
    end

    // Queue pointers, occupancy, entry contents and squash marking.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
            q_vld_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_r[i] <= ADDR_ZERO;
                q_data_r[i] <= DATA_ZERO;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pw_s && (q_addr_r[i] == rd)) begin
                    q_vld_r[i] <= 1'b0;
                end
            end
            if (pop_s) begin
                q_vld_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_ONE;
            end
            if (enq_s) begin
                q_vld_r[tail_r]  <= 1'b1;
                q_addr_r[tail_r] <= late.late_rd;
                q_data_r[tail_r] <= late.late_val;
                tail_r           <= tail_r + PTR_ONE;
            end
            case ({enq_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter: counts cycles the pipeline blocks a non-empty queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_r <= SC_ZERO;
            stall_r  <= 1'b0;
        end else if (empty_s || pop_s) begin
            starve_r <= SC_ZERO;
            stall_r  <= 1'b0;
        end else if (starve_r == SC_LAST) begin
            // This blocked cycle is number STARVE: force one drain cycle next.
            starve_r <= SC_ZERO;
            stall_r  <= 1'b1;
        end else begin
            starve_r <= starve_r + SC_ONE;
            stall_r  <= 1'b0;
        end
    end

    // Retire tracking: capture the slot when it is not stalled, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_valid_r <= 1'b0;
            pc_out_r       <= 30'd0;
            inst_out_r     <= 32'd0;
        end else if (slot_s) begin
            retire_valid_r <= 1'b1;
            pc_out_r       <= pc_in;
            inst_out_r     <= inst;
        end else begin
            retire_valid_r <= 1'b0;
        end
    end
endmodule
